// File: rtl/addsub_pkg.sv
// Shared types and flag derivation for the pipelined adder/subtractor.
// The carry-out is folded with the operation so that SUB reports a borrow.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic cb;
    logic ovf;
  } flags_t;

  // c_msb is the carry into the result MSB; with a + ~b + 1 a clear carry-out means a borrow
  function automatic flags_t flag_calc(input logic c_out, input logic c_msb, input op_e op);
    flags_t f;
    f.cb  = c_out ^ op;
    f.ovf = c_msb ^ c_out;
    return f;
  endfunction

endpackage

// File: rtl/addsub_pipe_chunk.sv
// One CHUNK-bit digit of the adder: a Kogge-Stone generate/propagate prefix,
// purely combinational, with optional inversion of b for subtraction.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic             invert_b,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] bx;
  logic [CHUNK-1:0] g0;
  logic [CHUNK-1:0] p0;
  logic [CHUNK-1:0] gg;
  logic [CHUNK-1:0] pp;
  logic [CHUNK:0]   c;

  always_comb begin
    bx = invert_b ? ~b : b;
    g0 = a & bx;
    p0 = a ^ bx;
    gg = g0;
    pp = p0;
    // Descending i within a level reads only not-yet-updated lower entries
    for (int unsigned d = 1; d < CHUNK; d = d * 2) begin
      for (int unsigned i = CHUNK - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      c[i+1] = gg[i] | (pp[i] & cin);
    end
    sum   = p0 ^ c[CHUNK-1:0];
    cout  = c[CHUNK];
    c_msb = c[CHUNK-1];
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor resolving one CHUNK-bit digit per
// stage, with skewed operands, a global stall and registered result flags.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  op_e              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cb,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $error("addsub_pipe: WIDTH must be a positive multiple of CHUNK");
  end

  // word_*: computed result digits below the current digit, raw a digits above it.
  // b_*: remaining raw b digits, right-aligned so the current digit sits at the LSBs.
  logic [WIDTH-1:0] word_d [STAGES];
  logic [WIDTH-1:0] word_n [STAGES];
  logic [WIDTH-1:0] word_q [STAGES];
  logic [WIDTH-1:0] b_d    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [CHUNK-1:0] sum    [STAGES];
  logic             c_d    [STAGES];
  logic             c_q    [STAGES];
  logic             cout   [STAGES];
  logic             cmsb   [STAGES];
  op_e              op_d   [STAGES];
  op_e              op_q   [STAGES];
  logic             v_d    [STAGES];
  logic             v_q    [STAGES];
  logic             stall;
  flags_t           flags;

  assign out_valid = v_q[LAST];
  assign out_res   = word_q[LAST];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  always_comb begin
    word_d[0] = in_a;
    b_d[0]    = in_b;
    c_d[0]    = in_op;
    op_d[0]   = in_op;
    v_d[0]    = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      word_d[k] = word_q[k-1];
      b_d[k]    = b_q[k-1];
      c_d[k]    = c_q[k-1];
      op_d[k]   = op_q[k-1];
      v_d[k]    = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_digit
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (word_d[k][k*CHUNK +: CHUNK]),
      .b        (b_d[k][CHUNK-1:0]),
      .cin      (c_d[k]),
      .invert_b (op_d[k]),
      .sum      (sum[k]),
      .cout     (cout[k]),
      .c_msb    (cmsb[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      word_n[k] = word_d[k];
      word_n[k][k*CHUNK +: CHUNK] = sum[k];
    end
    flags = flag_calc(cout[LAST], cmsb[LAST], op_d[LAST]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]    <= 1'b0;
        word_q[k] <= '0;
      end
      out_cb   <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]    <= v_d[k];
        word_q[k] <= word_n[k];
        b_q[k]    <= b_d[k] >> CHUNK;
        c_q[k]    <= cout[k];
        op_q[k]   <= op_d[k];
      end
      out_cb   <= flags.cb;
      out_ovf  <= flags.ovf;
      out_zero <= ~|word_n[LAST];
    end
  end

endmodule
